// File: rtl/instr_issue_unit.sv
// Instruction issue unit: fetches 16-bit words, decodes NOP/MOVE/MOVI/HALT and
// issues one-cycle start pulses. Optional WAIT watchdog enabled by IIU_WATCHDOG_EN.
module instr_issue_unit #(
  parameter int ADDR_W   = 4,
  parameter int WAIT_MAX = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_go,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              exec_done,
  output logic              start_move,
  output logic              start_movi,
  output logic [15:0]       ir,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic              timeout
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOVE = 4'b0001;
  localparam logic [3:0] OP_MOVI = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              illegal_q, illegal_d;

  logic is_nop, is_move, is_movi, is_halt, is_illegal;

  assign is_nop     = (ir_q[15:12] == OP_NOP);
  assign is_move    = (ir_q[15:12] == OP_MOVE);
  assign is_movi    = (ir_q[15:12] == OP_MOVI);
  assign is_halt    = (ir_q[15:12] == OP_HALT);
  assign is_illegal = !(is_nop || is_move || is_movi || is_halt);

`ifdef IIU_WATCHDOG_EN
  localparam int WD_W = ($clog2(WAIT_MAX + 1) < 6) ? 6 : $clog2(WAIT_MAX + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            wd_expire;

  // Expires on the WAIT cycle whose increment makes the count reach WAIT_MAX.
  assign wd_expire = (wd_cnt_q == WD_W'(WAIT_MAX - 1));

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q == S_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (!exec_done && wd_expire) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX != 0);
  assign timeout         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fetch_go) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_ISSUE;
      S_ISSUE: begin
        if (is_move || is_movi) state_d = S_WAIT;
        else if (is_halt)       state_d = S_HALT;
        else                    state_d = S_FETCH;
      end
      S_WAIT: begin
        if (exec_done) state_d = S_FETCH;
`ifdef IIU_WATCHDOG_EN
        else if (wd_expire) state_d = S_FETCH;
`endif
      end
      S_HALT:   if (fetch_go) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_move = 1'b0;
    start_movi = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_ISSUE: begin
        start_move = is_move;
        start_movi = is_movi;
      end
      default: ;
    endcase
  end

  // pc advances past every issued word except HALT, which holds until resumed.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_DECODE: ir_d = imem_data;
      S_ISSUE: begin
        if (!is_halt)   pc_d      = pc_q + 1'b1;
        if (is_illegal) illegal_d = 1'b1;
      end
      S_HALT: if (fetch_go) pc_d = pc_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: one ADDR_W=4 instance for the main
// scenarios and one ADDR_W=2 instance for pc wrap-around.
module tb_instr_issue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (ADDR_W=4)
  logic        reset, fetch_go, exec_done;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data, ir;
  logic        start_move, start_movi, busy, halted, illegal, timeout;
  logic [15:0] mem [16];

  // Wrap instance (ADDR_W=2)
  logic        reset2, fetch_go2, exec_done2;
  logic [1:0]  imem_addr2;
  logic [15:0] imem_data2, ir2;
  logic        start_move2, start_movi2, busy2, halted2, illegal2, timeout2;
  logic [15:0] mem2 [4];

  instr_issue_unit #(.ADDR_W(4), .WAIT_MAX(63)) u_dut (
    .clk(clk), .reset(reset), .fetch_go(fetch_go), .imem_addr(imem_addr),
    .imem_data(imem_data), .exec_done(exec_done), .start_move(start_move),
    .start_movi(start_movi), .ir(ir), .busy(busy), .halted(halted),
    .illegal(illegal), .timeout(timeout)
  );

  instr_issue_unit #(.ADDR_W(2), .WAIT_MAX(63)) u_dut2 (
    .clk(clk), .reset(reset2), .fetch_go(fetch_go2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .exec_done(exec_done2), .start_move(start_move2),
    .start_movi(start_movi2), .ir(ir2), .busy(busy2), .halted(halted2),
    .illegal(illegal2), .timeout(timeout2)
  );

  // Synchronous instruction memories: data valid one cycle after the address.
  always @(posedge clk) imem_data  <= mem[imem_addr];
  always @(posedge clk) imem_data2 <= mem2[imem_addr2];

  int n_move = 0;
  int n_movi = 0;
  always @(posedge clk) begin
    if (start_move) n_move <= n_move + 1;
    if (start_movi) n_movi <= n_movi + 1;
  end

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fetch_go  = 1'b0;
    exec_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  int  mo0, mv0, cnt;
  bit  found;
  logic exp_to, exp_movi;

  initial begin
    reset = 1'b1; fetch_go = 1'b0; exec_done = 1'b0;
    reset2 = 1'b1; fetch_go2 = 1'b0; exec_done2 = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h1000;

    // Reset state and single MOVE latency
    mem[0] = 16'h1000;
    mem[1] = 16'h1000;
    do_reset();
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_move", 32'(start_move), 0);
    chk("rst_movi", 32'(start_movi), 0);

    mo0 = n_move;
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk("lat_c1_busy", 32'(busy), 1);
    chk("lat_c1_move", 32'(start_move), 0);
    step();
    chk("lat_c2_move", 32'(start_move), 0);
    step();
    chk("lat_c3_move", 32'(start_move), 1);
    chk("lat_c3_movi", 32'(start_movi), 0);
    chk("lat_c3_ir", 32'(ir), 32'h1000);
    chk("lat_c3_addr", 32'(imem_addr), 0);
    exec_done = 1'b1;   // ignored during ISSUE
    fetch_go  = 1'b1;   // ignored during ISSUE and WAIT
    step();
    exec_done = 1'b0;
    chk("wait_move", 32'(start_move), 0);
    chk("wait_addr", 32'(imem_addr), 1);
    chk("wait_busy", 32'(busy), 1);
    repeat (6) step();
    fetch_go = 1'b0;
    chk("wait_hold_pulses", 32'(n_move - mo0), 1);
    chk("wait_hold_busy", 32'(busy), 1);

    // Back-to-back: pulse 3 cycles after exec_done is sampled
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("b2b_c1_move", 32'(start_move), 0);
    step();
    chk("b2b_c2_move", 32'(start_move), 0);
    step();
    chk("b2b_c3_move", 32'(start_move), 1);
    chk("b2b_c3_addr", 32'(imem_addr), 1);

    // MOVI, NOP, HALT then resume
    mem[0] = 16'h2005; mem[1] = 16'h0000; mem[2] = 16'hF000;
    do_reset();
    mo0 = n_move; mv0 = n_movi;
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    step();
    step();
    chk("movi_pulse", 32'(start_movi), 1);
    step();
    step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    repeat (6) step();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_pc", 32'(imem_addr), 2);
    chk("halt_movi_cnt", 32'(n_movi - mv0), 1);
    chk("halt_move_cnt", 32'(n_move - mo0), 0);
    step();
    chk("halt_hold", 32'(halted), 1);
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk("resume_pc", 32'(imem_addr), 3);
    chk("resume_busy", 32'(busy), 1);
    chk("resume_halted", 32'(halted), 0);

    // Illegal opcode
    mem[0] = 16'h7ABC; mem[1] = 16'hF000;
    do_reset();
    mo0 = n_move; mv0 = n_movi;
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    step();
    step();
    chk("ill_issue_flag", 32'(illegal), 0);
    step();
    chk("ill_set", 32'(illegal), 1);
    chk("ill_next_addr", 32'(imem_addr), 1);
    repeat (3) step();
    chk("ill_halted", 32'(halted), 1);
    chk("ill_sticky", 32'(illegal), 1);
    chk("ill_no_pulse", 32'((n_move - mo0) + (n_movi - mv0)), 0);
    do_reset();
    chk("ill_cleared", 32'(illegal), 0);

    // Reset in WAIT discards later exec_done
    mem[0] = 16'h1000; mem[1] = 16'h1000;
    do_reset();
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_addr", 32'(imem_addr), 0);
    chk("rw_move", 32'(start_move), 0);
    mo0 = n_move;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    repeat (4) step();
    chk("rw_idle", 32'(busy), 0);
    chk("rw_no_pulse", 32'(n_move - mo0), 0);

    // Reset in ISSUE wins over fetch_go
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    step();
    step();
    chk("ri_pulse", 32'(start_move), 1);
    reset = 1'b1;
    fetch_go = 1'b1;
    step();
    reset = 1'b0;
    fetch_go = 1'b0;
    chk("ri_move", 32'(start_move), 0);
    chk("ri_busy", 32'(busy), 0);

    // exec_done on the last watchdog cycle: completion wins
    mem[0] = 16'h1000; mem[1] = 16'h2000;
    do_reset();
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    repeat (3) step();
    repeat (62) step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("race_timeout", 32'(timeout), 0);
    chk("race_busy", 32'(busy), 1);
    step();
    step();
    chk("race_movi", 32'(start_movi), 1);

    // exec_done never returned
`ifdef IIU_WATCHDOG_EN
    exp_to = 1'b1; exp_movi = 1'b1;
`else
    exp_to = 1'b0; exp_movi = 1'b0;
`endif
    do_reset();
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    repeat (3) step();
    repeat (62) step();
    chk("wd_pre_timeout", 32'(timeout), 0);
    chk("wd_pre_addr", 32'(imem_addr), 1);
    step();
    chk("wd_timeout", 32'(timeout), 32'(exp_to));
    chk("wd_busy", 32'(busy), 1);
    step();
    step();
    chk("wd_next_issue", 32'(start_movi), 32'(exp_movi));

    // pc wrap with ADDR_W=2
    step();
    step();
    reset2 = 1'b0;
    fetch_go2 = 1'b1;
    step();
    fetch_go2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      found = 1'b0;
      cnt = 0;
      while (!found && cnt < 10) begin
        if (start_move2) found = 1'b1;
        else begin
          step();
          cnt++;
        end
      end
      chk($sformatf("wrap_pulse%0d", i), 32'(found), 1);
      chk($sformatf("wrap_addr%0d", i), 32'(imem_addr2), 32'(i % 4));
      step();
      exec_done2 = 1'b1;
      step();
      exec_done2 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
